// File: rtl/gray_counter_n.sv
// gray_counter_n: parametrised up/down Gray counter with binary view, clocked on the falling edge.
// Define GRAY_COUNTER_SAT_EN to saturate at the terminal count instead of wrapping.
module gray_counter_n #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RESET_BIN  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;
  logic             at_top;
  logic             at_bottom;

  assign count     = bin;
  assign at_top    = (bin == ALL_ONES);
  assign at_bottom = (bin == '0);
  assign tc        = up ? at_top : at_bottom;

  always_comb begin
    bin_next  = bin;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_val;
    end else if (en) begin
`ifdef GRAY_COUNTER_SAT_EN
      if (!tc) begin
        bin_next = up ? (bin + ONE) : (bin - ONE);
      end
`else
      bin_next  = up ? (bin + ONE) : (bin - ONE);
      wrap_next = tc;
`endif
    end
    gray_next = bin_next ^ (bin_next >> 1);
  end

  // Gray is registered from the next binary value so it never glitches.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      bin  <= RESET_BIN;
      gray <= RESET_GRAY;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: two instances (3-bit and 5-bit/RESET_VAL=17).
module tb_gray_counter_n;

  typedef struct {
    logic [15:0] count;
    logic [15:0] gray;
    logic        tc;
    logic        wrap;
    bit          step;
    string       name;
  } exp_t;

  logic clock;
  logic a_reset, a_en, a_up, a_load;
  logic [2:0] a_load_val, a_gray, a_count;
  logic a_tc, a_wrap;
  logic b_reset, b_en, b_up, b_load;
  logic [4:0] b_load_val, b_gray, b_count;
  logic b_tc, b_wrap;

  exp_t qa[$];
  exp_t qb[$];
  int total_checks = 0;
  int passed_checks = 0;
  logic [4:0] b_prev_gray;

  gray_counter_n #(.WIDTH(3), .RESET_VAL(0)) dut_a (
    .clock(clock), .reset(a_reset), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_load_val), .gray(a_gray), .count(a_count), .tc(a_tc), .wrap(a_wrap)
  );

  gray_counter_n #(.WIDTH(5), .RESET_VAL(17)) dut_b (
    .clock(clock), .reset(b_reset), .en(b_en), .up(b_up), .load(b_load),
    .load_val(b_load_val), .gray(b_gray), .count(b_count), .tc(b_tc), .wrap(b_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input string field,
                             input logic [15:0] actual, input logic [15:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, actual, expected);
  endtask

  // Inputs change just after the rising edge; the result is checked on the next rising edge.
  task automatic applyStimulus(input bit sel, input logic rst, input logic en, input logic up,
                               input logic ld, input logic [15:0] lv, input int cnt,
                               input int gry, input logic tc, input logic wr,
                               input bit step, input string name);
    exp_t e;
    @(posedge clock);
    #1;
    e.count = cnt[15:0];
    e.gray  = gry[15:0];
    e.tc    = tc;
    e.wrap  = wr;
    e.step  = step;
    e.name  = name;
    if (!sel) begin
      a_reset = rst; a_en = en; a_up = up; a_load = ld; a_load_val = lv[2:0];
      qa.push_back(e);
    end else begin
      b_reset = rst; b_en = en; b_up = up; b_load = ld; b_load_val = lv[4:0];
      qb.push_back(e);
    end
  endtask

  // Counting edge happens first, then reset drops between edges and must win at once.
  task automatic applyMidReset(input logic en, input logic up, input string name);
    exp_t e;
    @(posedge clock);
    #1;
    b_reset = 1'b1; b_en = en; b_up = up; b_load = 1'b0;
    e.count = 16'd17;
    e.gray  = 16'b11001;
    e.tc    = 1'b0;
    e.wrap  = 1'b0;
    e.step  = 1'b0;
    e.name  = name;
    qb.push_back(e);
    @(negedge clock);
    #1;
    b_reset = 1'b0;
  endtask

  always @(posedge clock) begin
    if (qa.size() > 0) begin
      exp_t e;
      e = qa.pop_front();
      checkOutput(e.name, "count", {13'd0, a_count}, e.count);
      checkOutput(e.name, "gray", {13'd0, a_gray}, e.gray);
      checkOutput(e.name, "tc", {15'd0, a_tc}, {15'd0, e.tc});
      checkOutput(e.name, "wrap", {15'd0, a_wrap}, {15'd0, e.wrap});
    end
  end

  always @(posedge clock) begin
    if (qb.size() > 0) begin
      exp_t e;
      e = qb.pop_front();
      checkOutput(e.name, "count", {11'd0, b_count}, e.count);
      checkOutput(e.name, "gray", {11'd0, b_gray}, e.gray);
      checkOutput(e.name, "tc", {15'd0, b_tc}, {15'd0, e.tc});
      checkOutput(e.name, "wrap", {15'd0, b_wrap}, {15'd0, e.wrap});
      if (e.step)
        checkOutput(e.name, "gray_bits_changed", 16'($countones(b_gray ^ b_prev_gray)), 16'd1);
      b_prev_gray = b_gray;
    end
  end

  initial begin
    int c, n;
    logic ren, rup, rtc, rwr;
    bit rstep;
    a_reset = 1'b1; a_en = 1'b0; a_up = 1'b0; a_load = 1'b0; a_load_val = '0;
    b_reset = 1'b1; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_load_val = '0;
    b_prev_gray = '0;
    #1;
    a_reset = 1'b0;
    b_reset = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 'b000, 1, 0, 0, "a_reset");
`ifdef GRAY_COUNTER_SAT_EN
    applyStimulus(0, 1, 1, 1, 0, 0, 1, 'b001, 0, 0, 0, "a_up1");
    applyStimulus(0, 1, 1, 1, 0, 0, 2, 'b011, 0, 0, 0, "a_up2");
    applyStimulus(0, 1, 1, 1, 0, 0, 3, 'b010, 0, 0, 0, "a_up3");
    applyStimulus(0, 1, 1, 1, 0, 0, 4, 'b110, 0, 0, 0, "a_up4");
    applyStimulus(0, 1, 1, 1, 0, 0, 5, 'b111, 0, 0, 0, "a_up5");
    applyStimulus(0, 1, 1, 1, 0, 0, 6, 'b101, 0, 0, 0, "a_up6");
    applyStimulus(0, 1, 1, 1, 0, 0, 7, 'b100, 1, 0, 0, "a_up7");
    applyStimulus(0, 1, 1, 1, 0, 0, 7, 'b100, 1, 0, 0, "a_sat_hold1");
    applyStimulus(0, 1, 1, 1, 0, 0, 7, 'b100, 1, 0, 0, "a_sat_hold2");
    applyStimulus(0, 1, 1, 1, 0, 0, 7, 'b100, 1, 0, 0, "a_sat_hold3");
    applyStimulus(0, 1, 1, 0, 0, 0, 6, 'b101, 0, 0, 0, "a_sat_reverse");
    applyStimulus(0, 1, 1, 0, 0, 0, 5, 'b111, 0, 0, 0, "a_dn5");
    applyStimulus(0, 1, 1, 0, 0, 0, 4, 'b110, 0, 0, 0, "a_dn4");
    applyStimulus(0, 1, 1, 0, 0, 0, 3, 'b010, 0, 0, 0, "a_dn3");
    applyStimulus(0, 1, 1, 0, 0, 0, 2, 'b011, 0, 0, 0, "a_dn2");
    applyStimulus(0, 1, 1, 0, 0, 0, 1, 'b001, 0, 0, 0, "a_dn1");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 'b000, 1, 0, 0, "a_dn0");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 'b000, 1, 0, 0, "a_sat_hold_low");
    applyStimulus(0, 1, 1, 1, 1, 3, 3, 'b010, 0, 0, 0, "a_load3");
`else
    applyStimulus(0, 1, 1, 1, 0, 0, 1, 'b001, 0, 0, 0, "a_up1");
    applyStimulus(0, 1, 1, 1, 0, 0, 2, 'b011, 0, 0, 0, "a_up2");
    applyStimulus(0, 1, 1, 1, 0, 0, 3, 'b010, 0, 0, 0, "a_up3");
    applyStimulus(0, 1, 1, 1, 0, 0, 4, 'b110, 0, 0, 0, "a_up4");
    applyStimulus(0, 1, 1, 1, 0, 0, 5, 'b111, 0, 0, 0, "a_up5");
    applyStimulus(0, 1, 1, 1, 0, 0, 6, 'b101, 0, 0, 0, "a_up6");
    applyStimulus(0, 1, 1, 1, 0, 0, 7, 'b100, 1, 0, 0, "a_up7");
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 'b000, 0, 1, 0, "a_up_wrap");
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 'b000, 0, 0, 0, "a_idle");
    applyStimulus(0, 1, 1, 0, 0, 0, 7, 'b100, 0, 1, 0, "a_dn_wrap");
    applyStimulus(0, 1, 1, 0, 0, 0, 6, 'b101, 0, 0, 0, "a_dn6");
    applyStimulus(0, 1, 1, 0, 0, 0, 5, 'b111, 0, 0, 0, "a_dn5");
    applyStimulus(0, 1, 1, 0, 0, 0, 4, 'b110, 0, 0, 0, "a_dn4");
    applyStimulus(0, 1, 1, 0, 0, 0, 3, 'b010, 0, 0, 0, "a_dn3");
    applyStimulus(0, 1, 1, 0, 0, 0, 2, 'b011, 0, 0, 0, "a_dn2");
    applyStimulus(0, 1, 1, 0, 0, 0, 1, 'b001, 0, 0, 0, "a_dn1");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 'b000, 1, 0, 0, "a_dn0");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 'b000, 1, 0, 0, "a_hold_tc_down");
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 'b000, 0, 0, 0, "a_dir_flip_tc");
    applyStimulus(0, 1, 0, 1, 1, 7, 7, 'b100, 1, 0, 0, "a_load7");
    applyStimulus(0, 1, 1, 1, 1, 2, 2, 'b011, 0, 0, 0, "a_load_beats_wrap");
    applyStimulus(0, 1, 1, 1, 0, 0, 3, 'b010, 0, 0, 0, "a_after_load");
    applyStimulus(0, 1, 1, 0, 1, 5, 5, 'b111, 0, 0, 0, "a_load_ignores_en");
    applyStimulus(0, 1, 1, 0, 0, 0, 4, 'b110, 0, 0, 0, "a_dn_after_load");
`endif
    applyStimulus(0, 1, 0, 0, 0, 0, 4, 'b110, 0, 0, 0, "a_final_hold");

    applyStimulus(1, 0, 0, 1, 0, 0, 17, 'b11001, 0, 0, 0, "b_reset");
    applyStimulus(1, 1, 1, 1, 0, 0, 18, 'b11011, 0, 0, 1, "b_up18");
    applyStimulus(1, 1, 1, 1, 0, 0, 19, 'b11010, 0, 0, 1, "b_up19");
    applyMidReset(1, 1, "b_mid_reset");
    applyStimulus(1, 1, 0, 1, 0, 0, 17, 'b11001, 0, 0, 0, "b_release");
    applyStimulus(1, 1, 0, 1, 1, 31, 31, 'b10000, 1, 0, 0, "b_load31");
    applyMidReset(1, 1, "b_reset_clears_wrap");
    applyStimulus(1, 1, 0, 1, 0, 0, 17, 'b11001, 0, 0, 0, "b_release2");

    // Random enable with sticky direction so the walk reaches both ends.
    c = 17;
    rup = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ren = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) rup = ~rup;
      n = c;
      rwr = 1'b0;
      rstep = 1'b0;
      if (ren) begin
`ifdef GRAY_COUNTER_SAT_EN
        if (!(rup ? (c == 31) : (c == 0))) begin
          n = rup ? (c + 1) % 32 : (c + 31) % 32;
          rstep = 1'b1;
        end
`else
        n = rup ? (c + 1) % 32 : (c + 31) % 32;
        rstep = 1'b1;
        rwr = rup ? (c == 31) : (c == 0);
`endif
      end
      rtc = rup ? (n == 31) : (n == 0);
      applyStimulus(1, 1, ren, rup, 0, 0, n, n ^ (n >> 1), rtc, rwr, rstep, "b_random");
      c = n;
    end

    for (int k = 0; k < 5 && (qa.size() > 0 || qb.size() > 0); k++) @(posedge clock);
    #1;
    if (qa.size() > 0 || qb.size() > 0) begin
      total_checks++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", qa.size() + qb.size());
    end
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
